dds_gen: RTL and testbench
==========================

Name: dds_gen

Overview:
- Parametrised direct digital synthesis generator, the next generation of the DSO/signal-generator DDS core.
- Generalises phase, address, data and amplitude widths.
- Adds a run-control state machine with continuous, burst and linear-frequency-sweep modes, plus an `out_valid` qualifier.
- Sine comes from an external single-port sine ROM (1-cycle read latency). Square, triangle and sawtooth are computed in logic, so the ROM holds only one table. Output feeds the DAC path at `sys_clk` rate.

Parameters:
- PHASE_W, 32: phase accumulator and frequency word width
- ADDR_W, 12: phase-to-amplitude address width (ROM depth 2^ADDR_W)
- DATA_W, 8: sample width, unsigned, midscale 2^(DATA_W-1)
- AMP_W, 9: amplitude control width; 2^(AMP_W-1) = unity gain
- CNT_W, 16: burst-length and sweep-dwell counter width

Ports:
- sys_clk, in, 1: DAC clock. Single clock domain.
- sys_rst, in, 1: synchronous, active-high reset.
- start, in, 1: pulse. Begins generation in the selected mode.
- stop, in, 1: pulse. Aborts to IDLE.
- mode, in, 2: 0 continuous, 1 burst, 2 sweep, 3 reserved (acts as continuous).
- wave_sel, in, 2: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- freq_ctl, in, PHASE_W: phase increment (continuous/burst).
- phase_ctl, in, ADDR_W: phase offset added to the address.
- amp_ctl, in, AMP_W: amplitude. Values above 2^(AMP_W-1) are clamped.
- burst_len, in, CNT_W: waveform periods per burst. 0 is treated as 1.
- sweep_start, in, PHASE_W: sweep start increment.
- sweep_stop, in, PHASE_W: sweep upper limit.
- sweep_step, in, PHASE_W: increment added per dwell.
- sweep_dwell, in, CNT_W: cycles per sweep step. 0 is treated as 1.
- rom_addr, out, ADDR_W: sine ROM read address.
- rom_data, in, DATA_W: sine ROM data, valid 1 cycle after `rom_addr`.
- data_out, out, DATA_W: waveform sample.
- out_valid, out, 1: `data_out` carries generated samples.
- busy, out, 1: state is not IDLE.
- done, out, 1: 1-cycle pulse at burst completion.
- sweep_wrap, out, 1: 1-cycle pulse when the sweep restarts at `sweep_start`.

Behaviour:
- Reset values: all outputs 0 except `data_out` = midscale. Accumulator, counters and pipeline are cleared. State is IDLE.
- States:
  - IDLE: accumulator held at 0.
  - RUN: continuous or reserved mode.
  - BURST
  - SWEEP
- Transitions:
  - IDLE + `start` → RUN, BURST or SWEEP per `mode`, sampled in the same cycle.
  - Any state + `stop` → IDLE next cycle. `stop` has priority over `start`.
  - `start` while busy is ignored.
- Accumulator:
  - acc <= acc + inc every non-IDLE cycle.
  - inc = `freq_ctl` in RUN/BURST; inc = freq_cur in SWEEP.
  - Modulo 2^PHASE_W. The carry-out is the period-wrap event.
- Burst:
  - Counts wraps. At the wrap that makes the count equal max(`burst_len`,1): next state IDLE, acc cleared, `done` pulses in that same cycle.
- Sweep:
  - freq_cur loads `sweep_start` on entry.
  - Every max(`sweep_dwell`,1) cycles, candidate = freq_cur + `sweep_step`, computed in PHASE_W+1 bits.
  - If candidate > `sweep_stop`: freq_cur <= `sweep_start` and `sweep_wrap` pulses.
  - Otherwise freq_cur <= candidate.
- Pipeline, one register per stage:
  - S1: addr = acc[PHASE_W-1 -: ADDR_W] + `phase_ctl`, mod 2^ADDR_W. Drives `rom_addr`.
  - S2: waveform = `rom_data` (sine); {DATA_W{addr MSB}} (square); addr MSB ? ~addr[ADDR_W-2 -: DATA_W] : addr[ADDR_W-2 -: DATA_W] (triangle); addr[ADDR_W-1 -: DATA_W] (saw). Non-sine values use the S1 address delayed 1 cycle so they align with the ROM.
  - S3: y = ((wave − mid) signed × amp_clamped) >>> (AMP_W−1), arithmetic shift.
  - S4: `data_out` = y + mid.
- Latency: `data_out` reflects the acc value from 4 cycles earlier. `out_valid` = non-IDLE state delayed 4 cycles.
- After returning to IDLE, the pipeline drains. `data_out` is midscale once `out_valid` deasserts.
- `wave_sel`, `amp_ctl`, `phase_ctl`, `freq_ctl` are used live, with no shadowing. A change takes effect at its pipeline stage.
- Synchronous reset mid-operation behaves exactly as power-up reset.

Optional Feature:
- Macro DDS_GEN_SWEEP_EN.
- Defined: SWEEP state, freq_cur, dwell counter and `sweep_wrap` are present.
- Undefined: none of that logic is built. `mode` = 2 behaves as continuous (RUN using `freq_ctl`), `sweep_wrap` is tied 0, and the `sweep_*` inputs are unused.

Test Plan:
- Reset, then `start` with mode=0, wave=3, freq=2^24, amp=256, phase=0 → `out_valid` rises 4 cycles after RUN entry; saw ramps 0,1,2…255 over a 256-cycle period; `busy`=1.
- Square, amp=128 → `data_out` alternates 191 and 64 every 128 cycles. Set amp=511 → clamps to unity, giving 255/0.
- Burst: mode=1, burst_len=3, freq=2^28 → exactly 48 generated cycles; `done` pulses once; `busy` falls; `data_out` returns to 128; burst_len=0 yields 16 cycles.
- Sweep (macro on): start=2^24, step=2^24, stop=3·2^24, dwell=10 → inc goes 1,2,3 (×2^24) in 10-cycle steps, then back to 1 with a `sweep_wrap` pulse. With the macro off → constant `freq_ctl` behaviour.
- Sine with phase_ctl=1024, ADDR_W=12 → `rom_addr` leads the zero-offset run by a quarter period; `data_out` equals the ROM model data × gain with 4-cycle alignment.
- `stop` and `start` asserted in the same cycle mid-burst → IDLE next cycle, no `done`. Reset asserted mid-sweep → all outputs at reset values next cycle.

Source files
------------

// File: rtl/dds_gen.sv
// dds_gen: parametrised DDS generator with continuous/burst/sweep run control.
// Linear frequency sweep is built only when DDS_GEN_SWEEP_EN is defined.
module dds_gen #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int AMP_W   = 9,
  parameter int CNT_W   = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] freq_ctl,
  input  logic [ADDR_W-1:0]  phase_ctl,
  input  logic [AMP_W-1:0]   amp_ctl,
  input  logic [CNT_W-1:0]   burst_len,
  input  logic [PHASE_W-1:0] sweep_start,
  input  logic [PHASE_W-1:0] sweep_stop,
  input  logic [PHASE_W-1:0] sweep_step,
  input  logic [CNT_W-1:0]   sweep_dwell,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  data_out,
  output logic               out_valid,
  output logic               busy,
  output logic               done,
  output logic               sweep_wrap
);

  typedef enum logic [1:0] {IDLE, RUN, BURST, SWEEP} state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [DATA_W-1:0] MID     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [AMP_W-1:0]  AMP_MAX = {1'b1, {(AMP_W-1){1'b0}}};

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] acc, inc;
  logic [PHASE_W:0]   acc_sum;
  logic               wrap, last_wrap, done_nxt;
  logic [CNT_W-1:0]   wrap_cnt, burst_tgt;

  assign busy      = (state != IDLE);
  assign acc_sum   = {1'b0, acc} + {1'b0, inc};
  assign wrap      = acc_sum[PHASE_W];
  assign burst_tgt = (burst_len == '0) ? CNT_ONE : burst_len;
  assign last_wrap = wrap && (wrap_cnt == burst_tgt - CNT_ONE);

`ifdef DDS_GEN_SWEEP_EN
  logic [PHASE_W-1:0] freq_cur;
  logic [CNT_W-1:0]   dwell_cnt, dwell_tgt;
  logic [PHASE_W:0]   cand;
  logic               step_now;

  assign inc       = (state == SWEEP) ? freq_cur : freq_ctl;
  assign dwell_tgt = (sweep_dwell == '0) ? CNT_ONE : sweep_dwell;
  assign step_now  = (state == SWEEP) && (dwell_cnt == dwell_tgt - CNT_ONE);
  assign cand      = {1'b0, freq_cur} + {1'b0, sweep_step};

  // freq_cur tracks sweep_start outside SWEEP so entry needs no extra load
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      freq_cur   <= '0;
      dwell_cnt  <= '0;
      sweep_wrap <= 1'b0;
    end else begin
      sweep_wrap <= 1'b0;
      if (state != SWEEP) begin
        freq_cur  <= sweep_start;
        dwell_cnt <= '0;
      end else if (step_now) begin
        dwell_cnt <= '0;
        if (cand > {1'b0, sweep_stop}) begin
          freq_cur   <= sweep_start;
          sweep_wrap <= 1'b1;
        end else begin
          freq_cur <= cand[PHASE_W-1:0];
        end
      end else begin
        dwell_cnt <= dwell_cnt + CNT_ONE;
      end
    end
  end
`else
  logic unused_sweep;

  assign inc          = freq_ctl;
  assign sweep_wrap   = 1'b0;
  assign unused_sweep = ^{sweep_start, sweep_stop, sweep_step, sweep_dwell};
`endif

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (mode)
              2'd1:    state_nxt = BURST;
`ifdef DDS_GEN_SWEEP_EN
              2'd2:    state_nxt = SWEEP;
`endif
              default: state_nxt = RUN;
            endcase
          end
        end
        BURST: begin
          if (last_wrap) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      acc      <= '0;
      wrap_cnt <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (state == IDLE || state_nxt == IDLE)
        acc <= '0;
      else
        acc <= acc_sum[PHASE_W-1:0];
      if (state != BURST)
        wrap_cnt <= '0;
      else if (wrap)
        wrap_cnt <= wrap_cnt + CNT_ONE;
    end
  end

  logic [ADDR_W-1:0]               addr_d;
  logic [3:0]                      vld;
  logic [DATA_W-1:0]               wave, y;
  logic [AMP_W-1:0]                amp_c;
  logic signed [DATA_W:0]          wave_c;
  logic signed [AMP_W:0]           gain;
  logic signed [DATA_W+AMP_W+1:0]  prod;

  // addr_d lines computed waves up with the ROM's own read register
  always_comb begin
    wave = rom_data;
    unique case (wave_sel)
      2'd1:    wave = {DATA_W{addr_d[ADDR_W-1]}};
      2'd2:    wave = addr_d[ADDR_W-1] ? ~addr_d[ADDR_W-2 -: DATA_W]
                                       :  addr_d[ADDR_W-2 -: DATA_W];
      2'd3:    wave = addr_d[ADDR_W-1 -: DATA_W];
      default: wave = rom_data;
    endcase
  end

  assign amp_c  = (amp_ctl > AMP_MAX) ? AMP_MAX : amp_ctl;
  assign gain   = $signed({1'b0, amp_c});
  assign wave_c = $signed({1'b0, wave}) - $signed({1'b0, MID});
  assign prod   = wave_c * gain;

  assign out_valid = vld[3];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rom_addr <= '0;
      addr_d   <= '0;
      vld      <= '0;
      y        <= '0;
      data_out <= MID;
    end else begin
      rom_addr <= acc[PHASE_W-1 -: ADDR_W] + phase_ctl;
      addr_d   <= rom_addr;
      vld      <= {vld[2:0], busy};
      y        <= vld[1] ? DATA_W'(prod >>> (AMP_W-1)) : '0;
      data_out <= y + MID;
    end
  end

endmodule

// File: tb/tb_dds_gen.sv
// tb_dds_gen: directed vector table plus burst, sweep, stop and reset sequences.
// Sweep expectations follow whether DDS_GEN_SWEEP_EN is defined.
module tb_dds_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst, start, stop;
  logic [1:0]  mode, wave_sel;
  logic [31:0] freq_ctl, sweep_start, sweep_stop, sweep_step;
  logic [11:0] phase_ctl, rom_addr;
  logic [8:0]  amp_ctl;
  logic [15:0] burst_len, sweep_dwell;
  logic [7:0]  rom_data, data_out;
  logic        out_valid, busy, done, sweep_wrap;

  int checks = 0;
  int errors = 0;

  dds_gen dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
    .mode(mode), .wave_sel(wave_sel), .freq_ctl(freq_ctl),
    .phase_ctl(phase_ctl), .amp_ctl(amp_ctl), .burst_len(burst_len),
    .sweep_start(sweep_start), .sweep_stop(sweep_stop),
    .sweep_step(sweep_step), .sweep_dwell(sweep_dwell),
    .rom_addr(rom_addr), .rom_data(rom_data), .data_out(data_out),
    .out_valid(out_valid), .busy(busy), .done(done),
    .sweep_wrap(sweep_wrap)
  );

  always #5 sys_clk = ~sys_clk;

  // ROM model: 1-cycle read, content a[7:0] ^ a[11:4]
  always @(posedge sys_clk)
    rom_data <= rom_addr[7:0] ^ rom_addr[11:4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (6) tick();
  endtask

  typedef struct {
    logic [1:0]  wave;
    logic [8:0]  amp;
    logic [11:0] phase;
    int          n;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[17];
  int   nv, bc, vc, dc, wc, wpos, exp_wc;
  logic [11:0] ra[42];
  logic [11:0] dlt;

  initial begin
    vecs[0]  = '{2'd3, 9'd256, 12'd0,    4,   8'd0};
    vecs[1]  = '{2'd3, 9'd256, 12'd0,    14,  8'd10};
    vecs[2]  = '{2'd3, 9'd256, 12'd0,    259, 8'd255};
    vecs[3]  = '{2'd3, 9'd256, 12'd0,    260, 8'd0};
    vecs[4]  = '{2'd1, 9'd128, 12'd0,    4,   8'd64};
    vecs[5]  = '{2'd1, 9'd128, 12'd0,    132, 8'd191};
    vecs[6]  = '{2'd1, 9'd511, 12'd0,    132, 8'd255};
    vecs[7]  = '{2'd1, 9'd511, 12'd0,    4,   8'd0};
    vecs[8]  = '{2'd2, 9'd256, 12'd0,    68,  8'd128};
    vecs[9]  = '{2'd2, 9'd256, 12'd0,    104, 8'd200};
    vecs[10] = '{2'd2, 9'd256, 12'd0,    196, 8'd127};
    vecs[11] = '{2'd3, 9'd0,   12'd0,    14,  8'd128};
    vecs[12] = '{2'd3, 9'd128, 12'd0,    14,  8'd69};
    vecs[13] = '{2'd3, 9'd64,  12'd0,    14,  8'd98};
    vecs[14] = '{2'd3, 9'd256, 12'd1024, 4,   8'd64};
    vecs[15] = '{2'd0, 9'd256, 12'd0,    9,   8'd85};
    vecs[16] = '{2'd0, 9'd256, 12'd1024, 9,   8'd21};
    nv = 17;

    sys_rst = 1'b1; start = 1'b0; stop = 1'b0;
    mode = 2'd0; wave_sel = 2'd3; freq_ctl = 32'h0100_0000;
    phase_ctl = '0; amp_ctl = 9'd256; burst_len = 16'd3;
    sweep_start = 32'h0100_0000; sweep_step = 32'h0100_0000;
    sweep_stop = 32'h0300_0000; sweep_dwell = 16'd10;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset data_out", data_out, 128);
    chk("reset done", done, 0);
    chk("reset sweep_wrap", sweep_wrap, 0);

    // run entry latency and busy
    pulse_start();
    chk("run busy", busy, 1);
    repeat (3) tick();
    chk("valid before 4", out_valid, 0);
    tick();
    chk("valid at 4", out_valid, 1);
    chk("saw first", data_out, 0);
    go_idle();
    chk("drain valid", out_valid, 0);
    chk("drain data", data_out, 128);

    for (int i = 0; i < nv; i++) begin
      wave_sel  = vecs[i].wave;
      amp_ctl   = vecs[i].amp;
      phase_ctl = vecs[i].phase;
      pulse_start();
      repeat (vecs[i].n) tick();
      chk($sformatf("vec%0d data_out", i), data_out, vecs[i].exp);
      go_idle();
    end

    // quarter-period lead of rom_addr with phase offset
    wave_sel = 2'd0; amp_ctl = 9'd256; phase_ctl = 12'd1024;
    pulse_start();
    repeat (3) tick();
    chk("rom_addr offset", rom_addr, 1024 + 32);
    go_idle();
    phase_ctl = '0;

    // burst of 3 periods at 16 cycles each
    mode = 2'd1; wave_sel = 2'd3; freq_ctl = 32'h1000_0000;
    burst_len = 16'd3;
    pulse_start();
    bc = 0; vc = 0; dc = 0;
    for (int i = 0; i < 100; i++) begin
      bc += int'(busy); vc += int'(out_valid); dc += int'(done);
      tick();
    end
    chk("burst3 busy cycles", bc, 48);
    chk("burst3 valid cycles", vc, 48);
    chk("burst3 done count", dc, 1);
    chk("burst3 busy end", busy, 0);
    chk("burst3 data end", data_out, 128);

    burst_len = 16'd0;
    pulse_start();
    vc = 0; dc = 0;
    for (int i = 0; i < 60; i++) begin
      vc += int'(out_valid); dc += int'(done);
      tick();
    end
    chk("burst0 valid cycles", vc, 16);
    chk("burst0 done count", dc, 1);

    // stop with start mid-burst
    burst_len = 16'd3;
    pulse_start();
    repeat (20) tick();
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    chk("stop busy", busy, 0);
    dc = 0;
    for (int i = 0; i < 60; i++) begin
      dc += int'(done);
      tick();
    end
    chk("stop done count", dc, 0);
    chk("stop data end", data_out, 128);
    chk("stop valid end", out_valid, 0);

    // sweep mode: rom_addr step per cycle shows the increment
    mode = 2'd2; freq_ctl = 32'h0100_0000;
    pulse_start();
    wc = 0; wpos = -1;
    for (int j = 0; j < 42; j++) begin
      ra[j] = rom_addr;
      if (sweep_wrap) begin
        wc++;
        wpos = j;
      end
      tick();
    end
    for (int j = 1; j < 40; j++) begin
      dlt = ra[j+1] - ra[j];
`ifdef DDS_GEN_SWEEP_EN
      chk($sformatf("sweep step %0d", j), dlt, 16 * (((j - 1) / 10) % 3 + 1));
`else
      chk($sformatf("sweep step %0d", j), dlt, 16);
`endif
    end
`ifdef DDS_GEN_SWEEP_EN
    exp_wc = 1;
    chk("sweep wrap pos", wpos, 30);
`else
    exp_wc = 0;
`endif
    chk("sweep wrap count", wc, exp_wc);

    // reset mid-sweep
    repeat (5) tick();
    sys_rst = 1'b1;
    tick();
    chk("rst busy", busy, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst data_out", data_out, 128);
    chk("rst rom_addr", rom_addr, 0);
    chk("rst done", done, 0);
    chk("rst sweep_wrap", sweep_wrap, 0);
    sys_rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
